// File: rtl/ifetch_queue.sv
// Purpose: fetch PC generator with one outstanding ICache request, static branch prediction, and a decoupling queue to Issue.
// Latency: a request rises one cycle after IDLE; a response is visible at the queue head the following cycle.
// Backpressure: is_stall holds the head; a full queue parks the fetcher in IDLE; rdy=0 freezes all state.
module ifetch_queue #(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_pc,
    input  logic        ic_rsp_valid,
    input  logic [31:0] ic_rsp_ins,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        is_stall,
    output logic        is_valid,
    output logic [31:0] is_ins,
    output logic [31:0] is_pc,
    output logic        is_pred_taken,
    output logic [31:0] is_pred_pc
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] npc;
    } entry_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    entry_t         mem_q [QDEPTH];

    logic           enq, deq;
    logic           pred_taken;
    logic [31:0]    pred_npc;
    logic [31:0]    imm_j, imm_b;
    entry_t         head_e;

    assign imm_j = {{11{ic_rsp_ins[31]}}, ic_rsp_ins[31], ic_rsp_ins[19:12],
                    ic_rsp_ins[20], ic_rsp_ins[30:21], 1'b0};
    assign imm_b = {{19{ic_rsp_ins[31]}}, ic_rsp_ins[31], ic_rsp_ins[7],
                    ic_rsp_ins[30:25], ic_rsp_ins[11:8], 1'b0};

    // Static prediction: JAL and backward conditional branches are taken, everything else falls through.
    always_comb begin
        pred_taken = 1'b0;
        pred_npc   = pc_q + 32'd4;
        if (ic_rsp_ins[6:0] == 7'b1101111) begin
            pred_taken = 1'b1;
            pred_npc   = pc_q + imm_j;
        end else if (ic_rsp_ins[6:0] == 7'b1100011 && ic_rsp_ins[31]) begin
            pred_taken = 1'b1;
            pred_npc   = pc_q + imm_b;
        end
    end

    // Next-state logic: flush outranks responses and dequeues; rdy=0 freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        enq     = 1'b0;
        deq     = 1'b0;
        if (rdy) begin
            if (flush) begin
                pc_d   = flush_pc;
                head_d = '0;
                tail_d = '0;
                cnt_d  = '0;
                if (state_q == WAIT) begin
                    state_d = ic_rsp_valid ? IDLE : DROP;
                end
            end else begin
                deq = (cnt_q != '0) && !is_stall;
                case (state_q)
                    IDLE: if (cnt_q < FULL) state_d = WAIT;
                    WAIT: if (ic_rsp_valid) begin
                        enq     = 1'b1;
                        pc_d    = pred_npc;
                        state_d = IDLE;
                    end
                    DROP: if (ic_rsp_valid) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
                if (enq) tail_d = tail_q + PW'(1);
                if (deq) head_d = head_q + PW'(1);
                cnt_d = cnt_q + CW'(enq) - CW'(deq);
            end
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue storage; contents are only observable while count is nonzero, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= '{ins: ic_rsp_ins, pc: pc_q, taken: pred_taken, npc: pred_npc};
        end
    end

    assign head_e        = mem_q[head_q];
    assign ic_req_valid  = (state_q == WAIT);
    assign ic_req_pc     = pc_q;
    assign is_valid      = (cnt_q != '0);
    assign is_ins        = is_valid ? head_e.ins : 32'h0;
    assign is_pc         = is_valid ? head_e.pc  : 32'h0;
    assign is_pred_taken = is_valid & head_e.taken;
    assign is_pred_pc    = is_valid ? head_e.npc : 32'h0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Purpose: directed self-checking bench for ifetch_queue with a 4-entry queue.
// Latency: inputs driven 1 time unit after each rising edge; outputs checked at that same point.
// Backpressure: exercises is_stall, full-queue hold, flush drain and rdy freeze.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        ic_req_valid;
    logic [31:0] ic_req_pc;
    logic        ic_rsp_valid = 1'b0;
    logic [31:0] ic_rsp_ins = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        is_stall = 1'b1;
    logic        is_valid;
    logic [31:0] is_ins;
    logic [31:0] is_pc;
    logic        is_pred_taken;
    logic [31:0] is_pred_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI  = 32'h00100093;  // addi x1,x0,1
    localparam logic [31:0] JAL16 = 32'h0100006F;  // jal x0,+16
    localparam logic [31:0] BEQB  = 32'hFE000CE3;  // beq x0,x0,-8
    localparam logic [31:0] BEQF  = 32'h00000463;  // beq x0,x0,+8

    ifetch_queue #(.QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .ic_req_valid  (ic_req_valid),
        .ic_req_pc     (ic_req_pc),
        .ic_rsp_valid  (ic_rsp_valid),
        .ic_rsp_ins    (ic_rsp_ins),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .is_stall      (is_stall),
        .is_valid      (is_valid),
        .is_ins        (is_ins),
        .is_pc         (is_pc),
        .is_pred_taken (is_pred_taken),
        .is_pred_pc    (is_pred_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic taken, input logic [31:0] npc);
        chk({tag, ".valid"}, 32'(is_valid), 32'd1);
        chk({tag, ".pc"},    is_pc, pc);
        chk({tag, ".ins"},   is_ins, ins);
        chk({tag, ".taken"}, 32'(is_pred_taken), 32'(taken));
        chk({tag, ".npc"},   is_pred_pc, npc);
    endtask

    // Bounded wait for a request; an expired bound shows up as a failed req_valid check.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (ic_req_valid) break;
            step();
        end
        chk({tag, ".req_valid"}, 32'(ic_req_valid), 32'd1);
    endtask

    // Accept the outstanding request at exp_pc and answer it lat cycles after it rose.
    task automatic serve(input string tag, input logic [31:0] exp_pc, input logic [31:0] ins, input int lat);
        wait_req(tag);
        chk({tag, ".req_pc"}, ic_req_pc, exp_pc);
        repeat (lat - 1) step();
        ic_rsp_valid = 1'b1;
        ic_rsp_ins   = ins;
        step();
        ic_rsp_valid = 1'b0;
        ic_rsp_ins   = 32'h0;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst.is_valid", 32'(is_valid), 32'd0);
        chk("rst.req_valid", 32'(ic_req_valid), 32'd0);
        chk("rst.req_pc", ic_req_pc, 32'h0);
        chk("rst.is_ins", is_ins, 32'h0);
        chk("rst.is_pc", is_pc, 32'h0);
        chk("rst.is_pred_pc", is_pred_pc, 32'h0);
        chk("rst.is_pred_taken", 32'(is_pred_taken), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("boot.req_valid", 32'(ic_req_valid), 32'd1);
        chk("boot.req_pc", ic_req_pc, 32'h0);

        // Sequential fetch with 3-cycle latency, Issue stalled
        serve("seq0", 32'h0, ADDI, 3);
        serve("seq1", 32'h4, ADDI, 3);
        serve("seq2", 32'h8, ADDI, 3);
        chk_head("head0", 32'h0, ADDI, 1'b0, 32'h4);
        is_stall = 1'b0;
        step();
        chk_head("head1", 32'h4, ADDI, 1'b0, 32'h8);
        step();
        chk_head("head2", 32'h8, ADDI, 1'b0, 32'hC);
        step();
        chk("drained.is_valid", 32'(is_valid), 32'd0);
        chk("wait12.req_pc", ic_req_pc, 32'hC);

        // Flush in the same cycle as a response
        flush = 1'b1; flush_pc = 32'h100;
        ic_rsp_valid = 1'b1; ic_rsp_ins = ADDI;
        step();
        flush = 1'b0; ic_rsp_valid = 1'b0;
        chk("flrsp.is_valid", 32'(is_valid), 32'd0);
        chk("flrsp.req_valid", 32'(ic_req_valid), 32'd0);
        step();
        chk("flrsp.req_valid2", 32'(ic_req_valid), 32'd1);
        chk("flrsp.req_pc", ic_req_pc, 32'h100);

        // JAL prediction
        is_stall = 1'b1;
        serve("jal", 32'h100, JAL16, 2);
        chk_head("jal", 32'h100, JAL16, 1'b1, 32'h110);
        wait_req("jal_next");
        chk("jal_next.req_pc", ic_req_pc, 32'h110);

        // Flush while WAIT, stale response two cycles later
        flush = 1'b1; flush_pc = 32'h400;
        step();
        flush = 1'b0;
        chk("drop.is_valid", 32'(is_valid), 32'd0);
        chk("drop.req_valid", 32'(ic_req_valid), 32'd0);
        step();
        chk("drop.req_valid2", 32'(ic_req_valid), 32'd0);
        ic_rsp_valid = 1'b1; ic_rsp_ins = JAL16;
        step();
        ic_rsp_valid = 1'b0;
        chk("stale.is_valid", 32'(is_valid), 32'd0);
        chk("stale.req_valid", 32'(ic_req_valid), 32'd0);
        step();
        chk("redir.req_valid", 32'(ic_req_valid), 32'd1);
        chk("redir.req_pc", ic_req_pc, 32'h400);

        // Flush in the same cycle as a dequeue
        serve("pre_fdq", 32'h400, ADDI, 1);
        chk_head("pre_fdq", 32'h400, ADDI, 1'b0, 32'h404);
        is_stall = 1'b0; flush = 1'b1; flush_pc = 32'h200;
        step();
        is_stall = 1'b1; flush = 1'b0;
        chk("fdq.is_valid", 32'(is_valid), 32'd0);
        chk("fdq.req_valid", 32'(ic_req_valid), 32'd0);
        step();
        chk("fdq.req_valid2", 32'(ic_req_valid), 32'd1);
        chk("fdq.req_pc", ic_req_pc, 32'h200);

        // Branch prediction and queue fill
        serve("beqb", 32'h200, BEQB, 2);
        serve("beqf", 32'h1F8, BEQF, 1);
        serve("fill2", 32'h1FC, ADDI, 1);
        serve("fill3", 32'h200, ADDI, 1);
        step();
        chk("full.req_valid", 32'(ic_req_valid), 32'd0);
        step();
        chk("full.req_valid2", 32'(ic_req_valid), 32'd0);
        chk_head("full_head", 32'h200, BEQB, 1'b1, 32'h1F8);
        is_stall = 1'b0;
        step();
        is_stall = 1'b1;
        chk("deq1.req_valid", 32'(ic_req_valid), 32'd0);
        chk_head("beqf_head", 32'h1F8, BEQF, 1'b0, 32'h1FC);
        step();
        chk("refill.req_valid", 32'(ic_req_valid), 32'd1);
        chk("refill.req_pc", ic_req_pc, 32'h204);
        is_stall = 1'b0;
        step();
        is_stall = 1'b1;
        chk_head("two_left", 32'h1FC, ADDI, 1'b0, 32'h200);

        // Asynchronous reset mid-WAIT with two entries queued
        #2;
        rst = 1'b0;
        #1;
        chk("arst.is_valid", 32'(is_valid), 32'd0);
        chk("arst.req_valid", 32'(ic_req_valid), 32'd0);
        chk("arst.req_pc", ic_req_pc, 32'h0);
        chk("arst.is_pc", is_pc, 32'h0);
        @(posedge clk);
        #1;
        chk("arst.held", 32'(ic_req_valid), 32'd0);
        rst = 1'b1;
        step();
        chk("restart.req_valid", 32'(ic_req_valid), 32'd1);
        chk("restart.req_pc", ic_req_pc, 32'h0);
        serve("restart", 32'h0, ADDI, 1);
        chk_head("restart", 32'h0, ADDI, 1'b0, 32'h4);

        // rdy=0 freezes the FSM and ignores responses
        rdy = 1'b0;
        step();
        step();
        chk("frz.req_valid", 32'(ic_req_valid), 32'd0);
        rdy = 1'b1;
        step();
        chk("frz.req_valid2", 32'(ic_req_valid), 32'd1);
        chk("frz.req_pc", ic_req_pc, 32'h4);
        rdy = 1'b0; ic_rsp_valid = 1'b1; ic_rsp_ins = BEQB;
        step();
        ic_rsp_valid = 1'b0; rdy = 1'b1;
        chk("frz_rsp.req_valid", 32'(ic_req_valid), 32'd1);
        chk("frz_rsp.req_pc", ic_req_pc, 32'h4);
        chk_head("frz_rsp", 32'h0, ADDI, 1'b0, 32'h4);
        is_stall = 1'b0;
        step();
        chk("frz_rsp.empty", 32'(is_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch front end with a decoupling instruction queue and static branch prediction. It sits between the ICache and Issue, and generates the fetch PC with one ICache request outstanding at a time. Each returned word is enqueued with its PC and predicted next PC. On a ROB/branch flush it redirects, discards any in-flight stale response, and empties the queue.

## Interface
Parameters:
- QDEPTH, 8, queue entries; power of two, at least 2.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- rdy  in  1  global enable; when 0, all state holds and no handshake completes.
- ic_req_valid  out  1  fetch request; held high until the response arrives.
- ic_req_pc  out  32  fetch address; stable while ic_req_valid=1.
- ic_rsp_valid  in  1  one-cycle pulse; the instruction for the outstanding request is valid.
- ic_rsp_ins  in  32  instruction word, valid with ic_rsp_valid.
- flush  in  1  redirect pulse.
- flush_pc  in  32  new fetch address.
- is_stall  in  1  Issue cannot accept this cycle.
- is_valid  out  1  queue head valid.
- is_ins  out  32  head instruction.
- is_pc  out  32  head PC.
- is_pred_taken  out  1  head was predicted taken.
- is_pred_pc  out  32  head predicted next PC.

## Operation
- FSM states: IDLE, WAIT, DROP. Registers: pc, queue array, head pointer, tail pointer, count (width clog2(QDEPTH)+1).
- ic_req_valid = (state==WAIT). ic_req_pc = pc.
- IDLE → WAIT when count < QDEPTH.
  - Only one request is outstanding, and count never rises while in WAIT, so a response always has a free slot.
- WAIT, ic_rsp_valid=1, no flush:
  - Enqueue {ic_rsp_ins, pc, taken, npc}.
  - Set pc ← npc and go to IDLE.
- Prediction, computed combinationally from ic_rsp_ins:
  - opcode 1101111 (JAL): taken, npc = pc + sext(immJ).
  - opcode 1100011 (branch) with ins[31]=1 (backward): taken, npc = pc + sext(immB).
  - Anything else, including JALR and forward branches: not taken, npc = pc + 4.
  - All adds are 32-bit modulo; wrap-around past 32'hFFFF_FFFC is permitted.
- Dequeue when is_valid && !is_stall: head advances and count decrements.
- Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo QDEPTH.
- Flush has priority over every other event in the same cycle:
  - Queue is emptied (head=tail, count=0) and pc ← flush_pc. Any dequeue that cycle is void.
  - From WAIT without ic_rsp_valid: go to DROP.
  - From WAIT with ic_rsp_valid the same cycle: the response is discarded and the state goes to IDLE.
  - From IDLE: stay in IDLE.
  - From DROP: pc ← flush_pc, stay in DROP.
- DROP: ic_req_valid=0. On ic_rsp_valid the word is discarded and the state goes to IDLE.
- rdy=0: no state change, and an ic_rsp_valid pulse is ignored. The ICache must not pulse the response while rdy=0.
- Reset, asynchronous at any time including mid-request:
  - state=IDLE, pc=RESET_PC, queue empty.
  - is_valid=0, ic_req_valid=0, ic_req_pc=RESET_PC.
  - is_ins, is_pc, is_pred_pc are 0 and is_pred_taken is 0.

## Timing
- IDLE at edge E: ic_req_valid is high in the cycle after E.
- Response in cycle N: the entry is visible on is_* in cycle N+1.
- Minimum fetch cadence is one instruction per 2 cycles plus ICache latency.
- Head outputs are driven from the queue array at head, with no extra register stage. is_valid = (count != 0).
- Flush in cycle F:
  - is_valid=0 in F+1.
  - The first request to flush_pc goes out in F+2 if the state was IDLE, otherwise after the stale response drains.
- Full queue (count=QDEPTH): remain in IDLE until a dequeue; the request rises one cycle after that dequeue edge.

## Test plan
- Reset then a 3-cycle ICache latency returning ADDI words → requests at pc 0, 4, 8. is_pc sequence is 0, 4, 8; is_pred_taken=0; is_pred_pc=pc+4.
- Response JAL x0,+16 at pc 0x100 → entry pred_taken=1, pred_pc 0x110; next ic_req_pc is 0x110. BEQ with offset −8 at 0x200 → next request 0x1F8. BEQ with offset +8 → 0x204.
- is_stall held at 1, QDEPTH=4 → exactly 4 entries enqueued, ic_req_valid stays low. Release is_stall for one cycle → one dequeue, and a new request appears on the next cycle.
- flush with flush_pc=0x400 while in WAIT, stale response 2 cycles later → stale word is not enqueued, queue is empty, and the next request has ic_req_pc 0x400.
- flush in the same cycle as ic_rsp_valid, and separately in the same cycle as a dequeue → nothing is enqueued, count=0, and the FSM is in IDLE the next cycle.
- Assert rst (drive to 0) mid-WAIT with 2 entries queued → is_valid=0 and ic_req_valid=0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
